// File: rtl/yasac_pkg.sv
// Shared definitions for the YASAC data path.
//   ALU operation encodings, opcode field width and instruction-word field helpers.
package yasac_pkg;

   localparam int unsigned OPCODE_W = 5;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_e;

   // Instruction word: {opcode[OPCODE_W], sela[ra], immediate[dw]}
   function automatic int unsigned ir_width(input int unsigned ra, input int unsigned dw);
      return OPCODE_W + ra + dw;
   endfunction

   function automatic int unsigned sela_lsb(input int unsigned dw);
      return dw;
   endfunction

   function automatic int unsigned opcode_lsb(input int unsigned ra, input int unsigned dw);
      return ra + dw;
   endfunction

endpackage

// File: rtl/alu_p.sv
// Combinational YASAC ALU.
//   op     : operation select (add, sub, and, or)
//   a, b   : operands
//   result : DW-bit result
//   carry  : add overflow / sub borrow (a < b), 0 for logic ops
//   zero   : result == 0
module alu_p
   import yasac_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  alu_op_e         op,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic [DW-1:0]   result,
   output logic            carry,
   output logic            zero
);

   logic [DW:0] ext;

   // One extra bit carries the add overflow or the subtract borrow.
   always_comb begin
      ext = '0;
      unique case (op)
         ALU_ADD: ext = {1'b0, a} + {1'b0, b};
         ALU_SUB: ext = {1'b0, a} - {1'b0, b};
         ALU_AND: ext = {1'b0, a & b};
         ALU_OR:  ext = {1'b0, a | b};
         default: ext = '0;
      endcase
   end

   assign result = ext[DW-1:0];
   assign carry  = ext[DW];
   assign zero   = (ext[DW-1:0] == '0);

endmodule

// File: rtl/data_unit_p.sv
// YASAC data path: program counter, instruction register, register array,
// ALU operand mux and registered condition flags.
// Optional return-address stack enabled by defining YASAC_CALL_STACK_EN.
//   clk, rst_n        : clock (rising edge), async active-low reset
//   operation         : ALU op select
//   incpc/clpc/loadpc : PC increment / clear / load immediate
//   call/ret          : push return address with loadpc / pop into PC
//   writeir           : IR <= code_data
//   writereg          : reg[sela] <= ALU result
//   writeflags        : latch zero/carry
//   inmediate         : ALU B from immediate instead of reg[selb]
//   data_in           : sampled into reg[RN-1] every cycle (unless written)
//   code_data/addr    : external code memory interface (addr = PC)
//   opcode            : IR opcode field
//   zero, carry       : registered flags
//   data_out          : reg[RN-2]
//   stack_err         : sticky stack over/underflow
module data_unit_p
   import yasac_pkg::*;
#(
   parameter int unsigned DW = 8,
   parameter int unsigned RA = 3,
   parameter int unsigned AW = 8,
   parameter int unsigned SD = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [1:0]                 operation,
   input  logic                       incpc,
   input  logic                       clpc,
   input  logic                       loadpc,
   input  logic                       writeir,
   input  logic                       writereg,
   input  logic                       writeflags,
   input  logic                       inmediate,
   input  logic                       call,
   input  logic                       ret,
   input  logic [DW-1:0]              data_in,
   input  logic [OPCODE_W+RA+DW-1:0]  code_data,
   output logic [AW-1:0]              code_addr,
   output logic [OPCODE_W-1:0]        opcode,
   output logic                       zero,
   output logic                       carry,
   output logic [DW-1:0]              data_out,
   output logic                       stack_err
);

   localparam int unsigned IW      = ir_width(RA, DW);
   localparam int unsigned RN      = 2 ** RA;
   localparam int unsigned OPC_LSB = opcode_lsb(RA, DW);
   localparam int unsigned SEL_LSB = sela_lsb(DW);

   logic [AW-1:0]  pc;
   logic [AW-1:0]  pc_nxt;
   logic [IW-1:0]  ir;
   logic [DW-1:0]  regs [RN];

   logic [RA-1:0]  sela;
   logic [RA-1:0]  selb;
   logic [DW-1:0]  imm;
   logic [DW-1:0]  alu_a;
   logic [DW-1:0]  alu_b;
   logic [DW-1:0]  alu_result;
   logic           alu_carry;
   logic           alu_zero;

   // IR field decode
   assign sela = ir[SEL_LSB +: RA];
   assign selb = ir[RA-1:0];
   assign imm  = ir[DW-1:0];

   // Operand mux; register reads are combinational
   assign alu_a = regs[sela];
   assign alu_b = inmediate ? imm : regs[selb];

   alu_p #(.DW(DW)) u_alu (
      .op     (alu_op_e'(operation)),
      .a      (alu_a),
      .b      (alu_b),
      .result (alu_result),
      .carry  (alu_carry),
      .zero   (alu_zero)
   );

`ifdef YASAC_CALL_STACK_EN
   localparam int unsigned SPW = $clog2(SD + 1);
   localparam int unsigned SIW = (SD > 1) ? $clog2(SD) : 1;

   logic [SPW-1:0] sp;
   logic [AW-1:0]  stack [SD];
   logic           stack_err_q;
   logic           st_full;
   logic           st_empty;
   logic           do_pop;
   logic           do_push;
   logic [AW-1:0]  st_top;

   // Stack moves only when the corresponding PC source is the winner.
   assign do_pop   = ret & ~clpc;
   assign do_push  = call & loadpc & ~ret & ~clpc;
   assign st_full  = (sp == SPW'(SD));
   assign st_empty = (sp == '0);
   assign st_top   = stack[SIW'(sp - SPW'(1))];

   // Stack pointer and sticky error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp          <= '0;
         stack_err_q <= 1'b0;
      end else if (do_pop) begin
         if (st_empty) stack_err_q <= 1'b1;
         else          sp          <= sp - SPW'(1);
      end else if (do_push) begin
         if (st_full)  stack_err_q <= 1'b1;
         else          sp          <= sp + SPW'(1);
      end
   end

   // Return-address storage, no reset needed
   always_ff @(posedge clk) begin
      if (do_push && !st_full) stack[SIW'(sp)] <= pc;
   end

   assign stack_err = stack_err_q;
`else
   logic unused_stack_ctl;
   assign unused_stack_ctl = call ^ ret;
   assign stack_err        = 1'b0;
`endif

   // PC next value: clpc > ret > loadpc > incpc
   always_comb begin
      pc_nxt = pc;
      if (clpc) begin
         pc_nxt = '0;
`ifdef YASAC_CALL_STACK_EN
      end else if (ret) begin
         if (!st_empty) pc_nxt = st_top;
`endif
      end else if (loadpc) begin
         pc_nxt = imm[AW-1:0];
      end else if (incpc) begin
         pc_nxt = pc + AW'(1);
      end
   end

   // PC and IR
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= '0;
         ir <= '0;
      end else begin
         pc <= pc_nxt;
         if (writeir) ir <= code_data;
      end
   end

   // Register array; an explicit write to the top register beats data_in
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RN; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < RN; i++) begin
            if (writereg && (sela == RA'(i))) regs[i] <= alu_result;
            else if (i == RN - 1)             regs[i] <= data_in;
         end
      end
   end

   // Condition flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero  <= 1'b0;
         carry <= 1'b0;
      end else if (writeflags) begin
         zero  <= alu_zero;
         carry <= alu_carry;
      end
   end

   assign code_addr = pc;
   assign opcode    = ir[OPC_LSB +: OPCODE_W];
   assign data_out  = regs[RN-2];

endmodule

// File: tb/tb_data_unit_p.sv
// Directed self-checking bench for data_unit_p at default parameters.
module tb_data_unit_p;
   import yasac_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [1:0]  operation;
   logic        incpc, clpc, loadpc, writeir, writereg, writeflags, inmediate;
   logic        call, ret;
   logic [7:0]  data_in;
   logic [15:0] code_data;
   logic [7:0]  code_addr;
   logic [4:0]  opcode;
   logic        zero, carry;
   logic [7:0]  data_out;
   logic        stack_err;

   int checks   = 0;
   int failures = 0;

   data_unit_p dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .operation  (operation),
      .incpc      (incpc),
      .clpc       (clpc),
      .loadpc     (loadpc),
      .writeir    (writeir),
      .writereg   (writereg),
      .writeflags (writeflags),
      .inmediate  (inmediate),
      .call       (call),
      .ret        (ret),
      .data_in    (data_in),
      .code_data  (code_data),
      .code_addr  (code_addr),
      .opcode     (opcode),
      .zero       (zero),
      .carry      (carry),
      .data_out   (data_out),
      .stack_err  (stack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ir(input logic [15:0] instr);
      code_data = instr;
      writeir   = 1'b1;
      tick();
      writeir   = 1'b0;
   endtask

   task automatic exec(input logic [15:0] instr, input logic [1:0] op,
                       input logic imm_sel, input logic wr, input logic wf);
      load_ir(instr);
      operation  = op;
      inmediate  = imm_sel;
      writereg   = wr;
      writeflags = wf;
      tick();
      writereg   = 1'b0;
      writeflags = 1'b0;
      inmediate  = 1'b0;
   endtask

   logic [7:0] tgt [5];
   logic [7:0] rtn [4];

   initial begin
      operation = 2'b00; incpc = 0; clpc = 0; loadpc = 0; writeir = 0;
      writereg = 0; writeflags = 0; inmediate = 0; call = 0; ret = 0;
      data_in = 8'h00; code_data = 16'h0000;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc",     32'(code_addr), 32'h00);
      chk("rst_opcode", 32'(opcode),    32'h00);
      chk("rst_dout",   32'(data_out),  32'h00);
      chk("rst_flags",  32'({zero, carry}), 32'h0);
      chk("rst_serr",   32'(stack_err), 32'h0);
      rst_n = 1'b1;
      tick();

      // Fetch: IR load plus PC increment
      code_data = 16'h0B05; writeir = 1; incpc = 1;
      tick();
      writeir = 0; incpc = 0;
      chk("fetch_pc",     32'(code_addr),       32'h01);
      chk("fetch_opcode", 32'(opcode),          32'h01);
      chk("fetch_sela",   32'(dut.ir[10:8]),    32'h3);
      chk("fetch_imm",    32'(dut.ir[7:0]),     32'h05);

      // reg3 = 0xFF, then 0xFF + 0x01 wraps with carry
      exec(16'h0BFF, ALU_OR, 1, 1, 0);
      chk("set_r3_ff", 32'(dut.regs[3]), 32'hFF);
      exec(16'h0B01, ALU_ADD, 1, 1, 1);
      chk("add_r3",    32'(dut.regs[3]), 32'h00);
      chk("add_zero",  32'(zero),  32'h1);
      chk("add_carry", 32'(carry), 32'h1);

      // Flags hold without writeflags; then 0x03 - 0x05 borrows
      exec(16'h0B03, ALU_OR, 1, 1, 0);
      chk("hold_flags", 32'({zero, carry}), 32'h3);
      exec(16'h0B05, ALU_SUB, 1, 1, 1);
      chk("sub_r3",    32'(dut.regs[3]), 32'hFE);
      chk("sub_carry", 32'(carry), 32'h1);
      chk("sub_zero",  32'(zero),  32'h0);

      // Flags-only AND: 0xFE & 0x0F = 0x0E, reg3 untouched
      exec(16'h0B0F, ALU_AND, 1, 0, 1);
      chk("and_r3",   32'(dut.regs[3]), 32'hFE);
      chk("and_flags", 32'({zero, carry}), 32'h0);

      // reg6 = 0x42 on data_out, then reg-mode add reg6 + reg3 = 0x140
      exec(16'h0642, ALU_OR, 1, 1, 0);
      chk("dout_42", 32'(data_out), 32'h42);
      exec(16'h0603, ALU_ADD, 0, 1, 1);
      chk("regb_add",   32'(data_out), 32'h40);
      chk("regb_flags", 32'({zero, carry}), 32'h1);

      // reg7: writereg wins over data_in, then data_in returns
      load_ir(16'h0710);
      data_in = 8'h77; operation = ALU_OR; inmediate = 1; writereg = 1;
      tick();
      writereg = 0; inmediate = 0;
      chk("r7_write_wins", 32'(dut.regs[7]), 32'h10);
      tick();
      chk("r7_data_in",    32'(dut.regs[7]), 32'h77);

      // PC priority and wrap
      load_ir(16'h0010); loadpc = 1; tick(); loadpc = 0;
      chk("pc_load10", 32'(code_addr), 32'h10);
      clpc = 1; loadpc = 1; incpc = 1; tick(); clpc = 0; loadpc = 0; incpc = 0;
      chk("pc_clr_prio", 32'(code_addr), 32'h00);
      load_ir(16'h0040); loadpc = 1; incpc = 1; tick(); loadpc = 0; incpc = 0;
      chk("pc_load_prio", 32'(code_addr), 32'h40);
      load_ir(16'h00FF); loadpc = 1; tick(); loadpc = 0;
      incpc = 1; tick(); incpc = 0;
      chk("pc_wrap", 32'(code_addr), 32'h00);

      // Mid-run async reset
      load_ir(16'h0023); loadpc = 1; tick(); loadpc = 0;
      exec(16'h0B00, ALU_AND, 1, 1, 0);
      exec(16'hFB5A, ALU_OR, 1, 1, 0);
      chk("pre_pc",  32'(code_addr),     32'h23);
      chk("pre_r3",  32'(dut.regs[3]),   32'h5A);
      chk("pre_opc", 32'(opcode),        32'h1F);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pc",    32'(code_addr),     32'h00);
      chk("arst_r3",    32'(dut.regs[3]),   32'h00);
      chk("arst_opc",   32'(opcode),        32'h00);
      chk("arst_dout",  32'(data_out),      32'h00);
      chk("arst_flags", 32'({zero, carry}), 32'h0);
      #2 rst_n = 1'b1;
      data_in = 8'h00;
      tick();

`ifdef YASAC_CALL_STACK_EN
      tgt = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
      rtn = '{8'h30, 8'h20, 8'h10, 8'h05};
      load_ir(16'h0005); loadpc = 1; tick(); loadpc = 0;
      for (int k = 0; k < 5; k++) begin
         load_ir({8'h00, tgt[k]});
         call = 1; loadpc = 1; tick(); call = 0; loadpc = 0;
         chk("call_pc",   32'(code_addr), 32'(tgt[k]));
         chk("call_serr", 32'(stack_err), (k == 4) ? 32'h1 : 32'h0);
      end
      for (int k = 0; k < 4; k++) begin
         ret = 1; tick(); ret = 0;
         chk("ret_pc", 32'(code_addr), 32'(rtn[k]));
      end
      ret = 1; tick(); ret = 0;
      chk("ret_empty_pc",   32'(code_addr), 32'h05);
      chk("ret_empty_serr", 32'(stack_err), 32'h1);
`else
      load_ir(16'h0030); call = 1; loadpc = 1; tick(); call = 0; loadpc = 0;
      chk("jump_pc",   32'(code_addr), 32'h30);
      ret = 1; tick(); ret = 0;
      chk("ret_ign_pc", 32'(code_addr), 32'h30);
      chk("no_serr",    32'(stack_err), 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_unit_p.md
Name: data_unit_p

Overview:
- Parametrised next-generation YASAC data path: program counter, instruction register, register array, ALU operand mux and registered condition flags.
- Adds PC branch loading, async active-low reset and an optional return-address stack.
- Code memory is external, reached via code_addr/code_data, so memories of any depth attach.
- Driven cycle-by-cycle by the control unit, which consumes opcode, zero and carry.

Parameters:
- DW, 8: data/register width, bits.
- RA, 3: register select width; register count RN = 2**RA.
- AW, 8: PC/code address width; must satisfy AW <= DW.
- SD, 4: return stack depth (used only with the optional feature).
- Derived localparam IW = 5 + RA + DW: instruction width (16 at defaults).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- operation  in  2  ALU op: 00 add, 01 sub (A-B), 10 and, 11 or
- incpc  in  1  PC increment
- clpc  in  1  PC clear
- loadpc  in  1  PC <= immediate[AW-1:0]
- writeir  in  1  IR <= code_data
- writereg  in  1  reg[sela] <= ALU result
- writeflags  in  1  latch zero/carry from ALU
- inmediate  in  1  ALU B = immediate instead of reg[selb]
- call  in  1  push return address (with loadpc)
- ret  in  1  pop return address into PC
- data_in  in  DW  external input, sampled into reg[RN-1]
- code_data  in  IW  instruction word from code memory
- code_addr  out  AW  = PC
- opcode  out  5  IR[IW-1:IW-5]
- zero  out  1  registered zero flag
- carry  out  1  registered carry/borrow flag
- data_out  out  DW  = reg[RN-2]
- stack_err  out  1  sticky stack over/underflow

Behaviour:
- Reset (rst_n low, async): PC, IR, all registers, zero, carry, stack pointer and stack_err all 0; outputs follow immediately, e.g. opcode=0, data_out=0.
- IR fields:
  - sela = IR[IW-6:DW]
  - immediate = IR[DW-1:0]
  - selb = IR[RA-1:0]
- PC priority per clock: clpc > ret > loadpc > incpc. Increment wraps 2**AW-1 -> 0.
- IR loads on writeir only; fetch = writeir+incpc in the same cycle, so during execute PC already points at the next instruction.
- Register array:
  - writereg writes ALU result to reg[sela].
  - reg[RN-1] takes data_in every cycle unless writereg targets sela=RN-1; the write wins.
  - Reads are combinational.
- ALU is combinational, 0-cycle. Result width DW, with carry out of bit DW:
  - add: carry = unsigned overflow.
  - sub: carry = 1 when A < B unsigned (borrow).
  - and/or: carry = 0.
  - zero = (result == 0).
- Flags update on the clock edge only when writeflags=1, otherwise hold. writereg and writeflags are independent and may coincide.
- loadpc and incpc both asserted: loadpc wins, no increment.

Optional Feature:
- YASAC_CALL_STACK_EN defined: SD-entry LIFO of AW-bit return addresses.
  - call=1 with loadpc=1 pushes the current PC and loads the immediate.
  - ret=1 pops the top into PC.
  - Push when full: PC still loads the target, push dropped, stack_err<=1.
  - Pop when empty: PC unchanged, stack_err<=1.
  - call and ret together: ret takes priority, call ignored.
  - stack_err clears only on reset.
- Macro undefined: call/ret ignored (call+loadpc acts as plain jump), stack_err tied 0, no stack storage.

Decomposition:
- Package yasac_pkg: ALU op encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR), opcode field width 5, IR field offset helpers.
- One sub-module: alu_p (parameter DW), combinational, outputs result, carry, zero.
- PC, IR, register array, flags and stack stay inline.

Test Plan:
- Reset mid-run with PC=0x23 and reg3=0x5A: assert rst_n=0 -> PC, regs, flags, opcode and data_out read 0 before the next clk edge.
- Fetch code_data=16'h0B05 with writeir+incpc at PC=0x00: -> PC=0x01, opcode=0x01, sela=3, immediate=0x05.
- Immediate add, reg3=0xFF + 0x01, writereg+writeflags: -> reg3=0x00, zero=1, carry=1. Sub 0x03-0x05: -> 0xFE, carry=1, zero=0.
- data_in=0x77 while writereg targets reg7 with result 0x10: -> reg7=0x10. Next cycle without writereg: -> reg7=0x77. reg6=0x42 -> data_out=0x42.
- PC priority, clpc+loadpc+incpc at PC=0x10: -> PC=0x00. loadpc+incpc with imm 0x40: -> PC=0x40. PC=0xFF with incpc: -> PC=0x00.
- With YASAC_CALL_STACK_EN, SD=4: five nested calls -> fifth sets stack_err, PC=target. Four rets return addresses in LIFO order. Fifth ret leaves PC unchanged, stack_err stays 1.
